// File: rtl/crc32_64_checker.sv
`default_nettype none
// ============================================================================
//  Module   : crc32_64_checker
//  Purpose  : Receive-side CRC-32 checker for 64-bit framed word streams.
//             A frame is N>=0 payload words followed by one trailer word whose
//             low 32 bits carry the CRC computed by the transmit generator.
//             Payload is forwarded downstream, the trailer is stripped, and
//             one pass/fail status is reported per frame. Saturating frame
//             and error counters are maintained.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             s_data/s_valid/s_sop/s_eop/s_ready   input word stream
//             m_data/m_valid/m_eop/m_ready         payload output stream
//             crc_done/crc_ok/crc_calc             per-frame check result
//             frame_cnt/err_cnt                    saturating statistics
//  Revision : 1.0  initial release
// ============================================================================
module crc32_64_checker #(
   parameter int DATA_BITS = 64,
   parameter int CRC_BITS  = 32,
   parameter int CNT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] s_data,
   input  logic                 s_valid,
   input  logic                 s_sop,
   input  logic                 s_eop,
   output logic                 s_ready,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   output logic                 m_eop,
   input  logic                 m_ready,
   output logic                 crc_done,
   output logic                 crc_ok,
   output logic [CRC_BITS-1:0]  crc_calc,
   output logic [CNT_BITS-1:0]  frame_cnt,
   output logic [CNT_BITS-1:0]  err_cnt
);

   localparam logic [CRC_BITS-1:0] C_SEED    = {CRC_BITS{1'b1}};
   localparam logic [CRC_BITS-1:0] C_POLY    = 32'h04C11DB7;
   localparam logic [CNT_BITS-1:0] C_CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
   localparam logic [CNT_BITS-1:0] C_CNT_MAX = {CNT_BITS{1'b1}};

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_CHECK   = 2'd2;

   // One 64-bit word folded into the CRC, MSB first (same matrix as the
   // transmit generator: no reflection, no final inversion).
   function automatic logic [CRC_BITS-1:0] crc_step(
      input logic [CRC_BITS-1:0]  c,
      input logic [DATA_BITS-1:0] d
   );
      logic [CRC_BITS-1:0] x;
      logic                fb;
      x = c;
      for (int i = DATA_BITS - 1; i >= 0; i--) begin
         fb = x[CRC_BITS-1] ^ d[i];
         x  = {x[CRC_BITS-2:0], 1'b0} ^ (fb ? C_POLY : {CRC_BITS{1'b0}});
      end
      return x;
   endfunction

   logic [1:0]           r_state;
   logic [1:0]           w_state_next;
   logic [CRC_BITS-1:0]  r_crc;
   logic [CRC_BITS-1:0]  r_trailer;
   logic [CRC_BITS-1:0]  r_crc_calc;
   logic [DATA_BITS-1:0] r_pend;        // newest payload word, awaiting its successor
   logic [DATA_BITS-1:0] r_h_data;      // holding register presented downstream
   logic                 r_h_full;
   logic                 r_h_eop;
   logic                 r_abort_done;
   logic [CNT_BITS-1:0]  r_frame_cnt;
   logic [CNT_BITS-1:0]  r_err_cnt;

   logic w_ready;
   logic w_in_beat;
   logic w_out_beat;
   logic w_start;     // word begins a frame with payload
   logic w_zero;      // sop & eop in IDLE: empty frame
   logic w_drop;      // beat in IDLE without sop
   logic w_abort;     // sop while a frame is open
   logic w_word;      // continuing payload word
   logic w_trailer;   // trailer closing an open frame
   logic w_check;
   logic w_match;
   logic w_release;   // pending word moves into the holding register

   // The holding register can take a word when empty or being drained.
   assign w_ready    = !rst && (r_state != ST_CHECK) && (!r_h_full || m_ready);
   assign w_in_beat  = s_valid && w_ready;
   assign w_out_beat = r_h_full && m_ready;
   assign w_match    = (r_crc == r_trailer);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_in_beat && s_sop) begin
               w_state_next = s_eop ? ST_CHECK : ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (w_in_beat) begin
               if (s_sop) begin
                  // An abort carrying sop & eop has no payload to restart with.
                  w_state_next = s_eop ? ST_IDLE : ST_PAYLOAD;
               end else if (s_eop) begin
                  w_state_next = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------- output decode
   always_comb begin
      w_start   = 1'b0;
      w_zero    = 1'b0;
      w_drop    = 1'b0;
      w_abort   = 1'b0;
      w_word    = 1'b0;
      w_trailer = 1'b0;
      w_check   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_start = w_in_beat && s_sop && !s_eop;
            w_zero  = w_in_beat && s_sop && s_eop;
            w_drop  = w_in_beat && !s_sop;
         end
         ST_PAYLOAD: begin
            w_abort   = w_in_beat && s_sop;
            w_start   = w_in_beat && s_sop && !s_eop;
            w_word    = w_in_beat && !s_sop && !s_eop;
            w_trailer = w_in_beat && !s_sop && s_eop;
         end
         ST_CHECK: begin
            w_check = 1'b1;
         end
         default: begin
            w_check = 1'b0;
         end
      endcase
      w_release = w_word || w_trailer || w_abort;
      s_ready   = w_ready;
      crc_done  = w_check || r_abort_done;
      crc_ok    = w_check && w_match;
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc        <= C_SEED;
         r_trailer    <= {CRC_BITS{1'b0}};
         r_crc_calc   <= {CRC_BITS{1'b0}};
         r_pend       <= {DATA_BITS{1'b0}};
         r_h_data     <= {DATA_BITS{1'b0}};
         r_h_full     <= 1'b0;
         r_h_eop      <= 1'b0;
         r_abort_done <= 1'b0;
      end else begin
         if (w_start) begin
            r_crc <= crc_step(C_SEED, s_data);
         end else if (w_word) begin
            r_crc <= crc_step(r_crc, s_data);
         end else if (w_check || w_zero || w_abort) begin
            r_crc <= C_SEED;
         end

         if (w_zero || w_trailer) begin
            r_trailer <= s_data[CRC_BITS-1:0];
         end

         // Result of the closing frame; r_crc is still the seed for an
         // empty frame.
         if (w_zero || w_trailer || w_abort) begin
            r_crc_calc <= r_crc;
         end

         if (w_start || w_word) begin
            r_pend <= s_data;
         end

         // A release only happens on an input beat, which already
         // guarantees the holding register is empty or draining.
         if (w_release) begin
            r_h_data <= r_pend;
            r_h_eop  <= w_trailer || w_abort;
            r_h_full <= 1'b1;
         end else if (w_out_beat) begin
            r_h_eop  <= 1'b0;
            r_h_full <= 1'b0;
         end

         r_abort_done <= w_abort;
      end
   end

   // ------------------------------------------------------------- counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= {CNT_BITS{1'b0}};
         r_err_cnt   <= {CNT_BITS{1'b0}};
      end else begin
         if (w_check && (r_frame_cnt != C_CNT_MAX)) begin
            r_frame_cnt <= r_frame_cnt + C_CNT_ONE;
         end
         // Drop, abort and failing check are mutually exclusive in time.
         if ((w_drop || w_abort || (w_check && !w_match)) && (r_err_cnt != C_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + C_CNT_ONE;
         end
      end
   end

   assign m_data    = r_h_data;
   assign m_valid   = r_h_full;
   assign m_eop     = r_h_eop;
   assign crc_calc  = r_crc_calc;
   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
